// File: rtl/cd_subcode_pkg.sv
// Shared types and constants for the CD subcode deserialiser.
// The Q-channel CRC helpers are only referenced when SUBCODE_QCRC_EN is defined.
package cd_subcode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_PUSH
    } state_t;

    localparam int          Q_BIT          = 6;
    localparam logic [15:0] QCRC_POLY      = 16'h1021;
    localparam int          QCRC_FIRST_IDX = 2;
    localparam int          QCRC_DATA_LAST = 81;
    localparam int          QCRC_LAST_IDX  = 97;

    // Entry layout for the default 8-bit / 98-symbol configuration; the top
    // declares the same layout at its parametrised widths.
    typedef struct packed {
        logic [7:0] data;
        logic       sob;
        logic [6:0] idx;
    } fifo_entry_t;

    // One bit of CRC-16 (x^16+x^12+x^5+1), MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? QCRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cd_subcode_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy, full/empty and clear.
// A pop and a push in the same cycle are both honoured even when full.
module cd_subcode_fifo
    import cd_subcode_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = fifo_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  entry_t        wr_data,
    input  logic          rd_en,
    output entry_t        rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam entry_t      ZERO      = '0;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_wr, do_rd;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign level   = count;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? ZERO : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cd_subcode_deserializer.sv
// CD subcode deserialiser: SCCK bursts per EFFK, MSB-first symbol assembly, block tagging, FIFO.
// Optional Q-channel CRC check is built when SUBCODE_QCRC_EN is defined.
module cd_subcode_deserializer
    import cd_subcode_pkg::*;
#(
    parameter int  BITS_PER_SYMBOL = 8,
    parameter int  FIFO_DEPTH      = 16,
    parameter int  FRAME_SYMBOLS   = 98,
    parameter int  INT_LEVEL       = 8,
    localparam int IDX_W           = $clog2(FRAME_SYMBOLS),
    localparam int LEVEL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       CCK,
    input  logic                       RST,
    input  logic                       EFFK,
    input  logic                       SCOR,
    input  logic                       SBCP,
    output logic                       SCCK,
    input  logic                       RD_EN,
    input  logic                       CLR,
    output logic [BITS_PER_SYMBOL-1:0] DATA,
    output logic                       SOB,
    output logic [IDX_W-1:0]           IDX,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic [LEVEL_W-1:0]         LEVEL,
    output logic                       OVERRUN,
    output logic                       SYNC_ERR,
    output logic                       INT_n
`ifdef SUBCODE_QCRC_EN
    ,
    output logic                       QCRC_OK,
    output logic                       QCRC_VLD
`endif
);

    localparam int                   BC_W     = (BITS_PER_SYMBOL > 1) ? $clog2(BITS_PER_SYMBOL) : 1;
    localparam logic [BC_W-1:0]      LAST_BIT = BC_W'(BITS_PER_SYMBOL - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FRAME_SYMBOLS - 1);
    localparam logic [LEVEL_W-1:0]   INT_CNT  = LEVEL_W'(INT_LEVEL);

    typedef struct packed {
        logic [BITS_PER_SYMBOL-1:0] data;
        logic                       sob;
        logic [IDX_W-1:0]           idx;
    } entry_t;

    state_t                     state, state_next;
    logic [2:0]                 effk_sync, scor_sync;
    logic                       effk_pulse, scor_pulse;
    logic [BC_W-1:0]            bit_cnt;
    logic [BITS_PER_SYMBOL-1:0] shift_q;
    logic [IDX_W-1:0]           idx_q, tag_idx;
    logic                       pend_sob, tag_sob, push;
    entry_t                     wr_entry, head;

    // Two synchroniser flops plus a history flop; the edge pulse is registered.
    always_ff @(posedge CCK or posedge RST) begin
        if (RST) begin
            effk_sync  <= '0;
            scor_sync  <= '0;
            effk_pulse <= 1'b0;
            scor_pulse <= 1'b0;
        end else begin
            effk_sync  <= {effk_sync[1:0], EFFK};
            scor_sync  <= {scor_sync[1:0], SCOR};
            effk_pulse <= effk_sync[1] & ~effk_sync[2];
            scor_pulse <= scor_sync[1] & ~scor_sync[2];
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        SCCK       = 1'b0;
        push       = 1'b0;
        case (state)
            ST_IDLE: if (effk_pulse) state_next = ST_HI;
            ST_HI: begin
                SCCK       = 1'b1;
                state_next = ST_LO;
            end
            ST_LO:   state_next = (bit_cnt == LAST_BIT) ? ST_PUSH : ST_HI;
            ST_PUSH: begin
                push       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The block tag is captured at burst start, so an SCOR landing mid-burst
    // only affects the following symbol.
    always_ff @(posedge CCK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            pend_sob <= 1'b0;
            tag_sob  <= 1'b0;
            tag_idx  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && effk_pulse) begin
                bit_cnt  <= '0;
                tag_sob  <= pend_sob | scor_pulse;
                tag_idx  <= (pend_sob | scor_pulse) ? '0 : idx_q;
                pend_sob <= 1'b0;
            end else if (scor_pulse) begin
                pend_sob <= 1'b1;
            end
            if (state == ST_HI) shift_q <= {shift_q[BITS_PER_SYMBOL-2:0], SBCP};
            if (state == ST_LO && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
            if (push) idx_q <= (tag_idx == IDX_LAST) ? '0 : tag_idx + 1'b1;
        end
    end

    assign wr_entry = '{data: shift_q, sob: tag_sob, idx: tag_idx};

    cd_subcode_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (CCK),
        .rst     (RST),
        .clr     (CLR),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (RD_EN),
        .rd_data (head),
        .empty   (EMPTY),
        .full    (FULL),
        .level   (LEVEL)
    );

    assign DATA = head.data;
    assign SOB  = head.sob;
    assign IDX  = head.idx;

    always_ff @(posedge CCK or posedge RST) begin
        if (RST) begin
            OVERRUN  <= 1'b0;
            SYNC_ERR <= 1'b0;
            INT_n    <= 1'b1;
        end else begin
            if (CLR) begin
                OVERRUN  <= 1'b0;
                SYNC_ERR <= 1'b0;
            end else begin
                if (push && FULL && !RD_EN) OVERRUN <= 1'b1;
                if (effk_pulse && state != ST_IDLE) SYNC_ERR <= 1'b1;
            end
            INT_n <= ~((LEVEL >= INT_CNT) | OVERRUN | SYNC_ERR);
        end
    end

`ifdef SUBCODE_QCRC_EN
    generate
        if (BITS_PER_SYMBOL == 8 && FRAME_SYMBOLS >= 98) begin : g_qcrc
            logic [15:0] crc_q, rx_q;
            logic        q_bit;
            assign q_bit = shift_q[Q_BIT];

            // CRC over Q of indices 2..81; indices 82..97 carry the inverted CRC, MSB first.
            always_ff @(posedge CCK or posedge RST) begin
                if (RST) begin
                    crc_q    <= '0;
                    rx_q     <= '0;
                    QCRC_OK  <= 1'b0;
                    QCRC_VLD <= 1'b0;
                end else begin
                    QCRC_VLD <= 1'b0;
                    if (push) begin
                        if (tag_idx == IDX_W'(QCRC_FIRST_IDX))
                            crc_q <= crc16_step(16'h0000, q_bit);
                        else if (tag_idx > IDX_W'(QCRC_FIRST_IDX) && tag_idx <= IDX_W'(QCRC_DATA_LAST))
                            crc_q <= crc16_step(crc_q, q_bit);
                        else if (tag_idx > IDX_W'(QCRC_DATA_LAST) && tag_idx <= IDX_W'(QCRC_LAST_IDX))
                            rx_q <= {rx_q[14:0], ~q_bit};
                        if (tag_idx == IDX_W'(QCRC_LAST_IDX)) begin
                            QCRC_VLD <= 1'b1;
                            QCRC_OK  <= ({rx_q[14:0], ~q_bit} == crc_q);
                        end
                    end
                end
            end
        end else begin : g_no_qcrc
            assign QCRC_OK  = 1'b0;
            assign QCRC_VLD = 1'b0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_cd_subcode_deserializer.sv
// Self-checking bench for cd_subcode_deserializer: directed bursts, tables and corner sequences.
// The Q-CRC section is compiled only when SUBCODE_QCRC_EN is defined.
module tb_cd_subcode_deserializer;

    logic       CCK = 1'b0;
    logic       RST, EFFK, SCOR, SBCP, RD_EN, CLR;
    logic       SCCK, SOB, EMPTY, FULL, OVERRUN, SYNC_ERR, INT_n;
    logic [7:0] DATA;
    logic [6:0] IDX;
    logic [4:0] LEVEL;
`ifdef SUBCODE_QCRC_EN
    logic       qcrc_ok, qcrc_vld;
`endif

    int checks = 0;
    int errors = 0;

    cd_subcode_deserializer dut (
        .CCK      (CCK),
        .RST      (RST),
        .EFFK     (EFFK),
        .SCOR     (SCOR),
        .SBCP     (SBCP),
        .SCCK     (SCCK),
        .RD_EN    (RD_EN),
        .CLR      (CLR),
        .DATA     (DATA),
        .SOB      (SOB),
        .IDX      (IDX),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .LEVEL    (LEVEL),
        .OVERRUN  (OVERRUN),
        .SYNC_ERR (SYNC_ERR),
        .INT_n    (INT_n)
`ifdef SUBCODE_QCRC_EN
        ,
        .QCRC_OK  (qcrc_ok),
        .QCRC_VLD (qcrc_vld)
`endif
    );

    always #5 CCK = ~CCK;

    // SCCK pulse counter and high-width monitor, sampled on the falling edge.
    int   scck_pulses = 0;
    int   hi_run      = 0;
    int   width_errs  = 0;
    logic scck_prev   = 1'b0;
    always @(negedge CCK) begin
        if (SCCK === 1'b1) begin
            hi_run++;
            if (scck_prev !== 1'b1) scck_pulses++;
            if (hi_run > 1) width_errs++;
        end else begin
            hi_run = 0;
        end
        scck_prev = SCCK;
    end

`ifdef SUBCODE_QCRC_EN
    int   vld_count = 0;
    logic ok_at_vld = 1'b0;
    always @(negedge CCK) begin
        if (qcrc_vld === 1'b1) begin
            vld_count++;
            ok_at_vld = qcrc_ok;
        end
    end
`endif

    typedef struct {
        logic [7:0] sbcp;
        logic [7:0] exp_data;
        logic [6:0] exp_idx;
        logic       exp_sob;
    } vec_t;

    vec_t vecs[4];

    task automatic tick(input int n);
        repeat (n) @(negedge CCK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_scck(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CCK);
            if (SCCK === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pop();
        RD_EN = 1'b1;
        tick(1);
        RD_EN = 1'b0;
    endtask

    task automatic pulse_effk();
        EFFK = 1'b1;
        tick(2);
        EFFK = 1'b0;
    endtask

    // One full burst; SBCP is presented while SCCK is high so it is shifted at the end of HI.
    task automatic run_burst(input logic [7:0] bits, input bit pop_at_push, input int effk_at_bit);
        bit ok;
        pulse_effk();
        for (int k = 0; k < 8; k++) begin
            wait_scck(ok);
            if (!ok) begin
                check("scck_timeout", 32'(ok), 32'd1);
                return;
            end
            SBCP = bits[7-k];
            if (k == effk_at_bit) EFFK = 1'b1;
            if (k == effk_at_bit + 2) EFFK = 1'b0;
        end
        tick(2);
        if (pop_at_push) RD_EN = 1'b1;
        tick(1);
        RD_EN = 1'b0;
        tick(2);
    endtask

    initial begin
        int         base, bad;
        bit         ok;
        logic [7:0] exp_b;
        logic [7:0] sym_data [98];
        logic [15:0] crc;
        logic        fb;

        RST = 1'b1; EFFK = 1'b0; SCOR = 1'b0; SBCP = 1'b0; RD_EN = 1'b0; CLR = 1'b0;

        vecs[0] = '{sbcp: 8'h00, exp_data: 8'h00, exp_idx: 7'd1, exp_sob: 1'b0};
        vecs[1] = '{sbcp: 8'hFF, exp_data: 8'hFF, exp_idx: 7'd2, exp_sob: 1'b0};
        vecs[2] = '{sbcp: 8'h5A, exp_data: 8'h5A, exp_idx: 7'd3, exp_sob: 1'b0};
        vecs[3] = '{sbcp: 8'h81, exp_data: 8'h81, exp_idx: 7'd4, exp_sob: 1'b0};

        // Reset values
        tick(2);
        check("rst_scck", 32'(SCCK), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_data", 32'(DATA), 32'd0);
        check("rst_idx", 32'(IDX), 32'd0);
        check("rst_sob", 32'(SOB), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);
        check("rst_sync_err", 32'(SYNC_ERR), 32'd0);
        check("rst_int_n", 32'(INT_n), 32'd1);
        RST = 1'b0;
        tick(2);

        // Burst timing: 1,0,1,1,0,0,1,0 -> 0xB2
        base = scck_pulses;
        run_burst(8'hB2, 1'b0, -1);
        check("burst_pulses", 32'(scck_pulses - base), 32'd8);
        check("burst_hi_width", 32'(width_errs), 32'd0);
        check("burst_data", 32'(DATA), 32'hB2);
        check("burst_level", 32'(LEVEL), 32'd1);
        check("burst_int_n", 32'(INT_n), 32'd1);
        check("burst_idx", 32'(IDX), 32'd0);
        check("burst_sob", 32'(SOB), 32'd0);
        pop();
        pop();
        check("underflow_level", 32'(LEVEL), 32'd0);
        check("underflow_empty", 32'(EMPTY), 32'd1);

        // Table-driven symbols with sequential indices
        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i].sbcp, 1'b0, -1);
            check($sformatf("vec%0d_data", i), 32'(DATA), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_idx", i), 32'(IDX), 32'(vecs[i].exp_idx));
            check($sformatf("vec%0d_sob", i), 32'(SOB), 32'(vecs[i].exp_sob));
            check($sformatf("vec%0d_level", i), 32'(LEVEL), 32'd1);
            pop();
        end

        // SOB alignment across 100 symbols
        SCOR = 1'b1;
        tick(2);
        SCOR = 1'b0;
        tick(4);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            exp_b = 8'(i * 37 + 5);
            run_burst(exp_b, 1'b0, -1);
            if (i == 0) begin
                check("sob_first_sob", 32'(SOB), 32'd1);
                check("sob_first_idx", 32'(IDX), 32'd0);
            end
            if (i == 98) begin
                check("sob_wrap_idx", 32'(IDX), 32'd0);
                check("sob_wrap_sob", 32'(SOB), 32'd0);
            end
            if (i == 99) check("sob_after_wrap_idx", 32'(IDX), 32'd1);
            if (DATA !== exp_b || IDX !== 7'(i % 98) || SOB !== (i == 0)) bad++;
            pop();
        end
        check("sob_sequence_bad", 32'(bad), 32'd0);

        // Overrun: 17 bursts without popping
        for (int i = 0; i < 17; i++) begin
            run_burst(8'(8'h10 + i), 1'b0, -1);
            if (i == 15) begin
                check("ovr_full16", 32'(FULL), 32'd1);
                check("ovr_level16", 32'(LEVEL), 32'd16);
                check("ovr_not_yet", 32'(OVERRUN), 32'd0);
            end
        end
        check("ovr_overrun", 32'(OVERRUN), 32'd1);
        check("ovr_int_n", 32'(INT_n), 32'd0);
        check("ovr_level17", 32'(LEVEL), 32'd16);
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            if (DATA !== 8'(8'h10 + j)) bad++;
            pop();
        end
        check("ovr_drain_bad", 32'(bad), 32'd0);
        check("ovr_17th_absent", 32'(EMPTY), 32'd1);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        tick(1);
        check("clr_overrun", 32'(OVERRUN), 32'd0);
        check("clr_empty", 32'(EMPTY), 32'd1);
        check("clr_int_n", 32'(INT_n), 32'd1);

        // Full with simultaneous pop at PUSH
        for (int i = 0; i < 16; i++) run_burst(8'(8'h20 + i), 1'b0, -1);
        check("fp_full", 32'(FULL), 32'd1);
        run_burst(8'h99, 1'b1, -1);
        check("fp_level", 32'(LEVEL), 32'd16);
        check("fp_overrun", 32'(OVERRUN), 32'd0);
        check("fp_head", 32'(DATA), 32'h21);
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            exp_b = (j == 15) ? 8'h99 : 8'(8'h21 + j);
            if (DATA !== exp_b) bad++;
            pop();
        end
        check("fp_drain_bad", 32'(bad), 32'd0);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        tick(2);

        // Sync error: second EFFK raised during bit 2 of the burst
        base = scck_pulses;
        run_burst(8'hC3, 1'b0, 2);
        check("sync_pulses", 32'(scck_pulses - base), 32'd8);
        check("sync_err", 32'(SYNC_ERR), 32'd1);
        check("sync_level", 32'(LEVEL), 32'd1);
        check("sync_data", 32'(DATA), 32'hC3);
        tick(40);
        check("sync_no_extra_burst", 32'(scck_pulses - base), 32'd8);
        check("sync_level_late", 32'(LEVEL), 32'd1);
        check("sync_int_n", 32'(INT_n), 32'd0);

        // Reset in the LO phase of bit 3 (one symbol still queued)
        pulse_effk();
        for (int k = 0; k < 4; k++) begin
            wait_scck(ok);
            if (!ok) check("rstmid_timeout", 32'(ok), 32'd1);
            SBCP = k[0];
        end
        tick(1);
        #1 RST = 1'b1;
        #1;
        check("rstmid_scck", 32'(SCCK), 32'd0);
        check("rstmid_empty", 32'(EMPTY), 32'd1);
        check("rstmid_sync_err", 32'(SYNC_ERR), 32'd0);
        tick(2);
        RST = 1'b0;
        base = scck_pulses;
        tick(30);
        check("rstmid_no_resume", 32'(scck_pulses - base), 32'd0);
        check("rstmid_still_empty", 32'(EMPTY), 32'd1);
        run_burst(8'h3C, 1'b0, -1);
        check("rstmid_next_pulses", 32'(scck_pulses - base), 32'd8);
        check("rstmid_next_data", 32'(DATA), 32'h3C);
        check("rstmid_next_idx", 32'(IDX), 32'd0);
        check("rstmid_next_level", 32'(LEVEL), 32'd1);
        pop();

`ifdef SUBCODE_QCRC_EN
        // Q-channel CRC: one good block, then one with a flipped Q bit
        for (int pass = 0; pass < 2; pass++) begin
            crc = 16'h0000;
            for (int i = 0; i < 98; i++) begin
                sym_data[i] = {1'b1, 1'b0, 6'(i)};
                if (i >= 2 && i <= 81) begin
                    sym_data[i][6] = ((i * 5) % 3) == 1;
                    fb  = crc[15] ^ sym_data[i][6];
                    crc = {crc[14:0], 1'b0};
                    if (fb) crc = crc ^ 16'h1021;
                end
            end
            for (int k = 0; k < 16; k++) sym_data[82+k][6] = ~crc[15-k];
            if (pass == 1) sym_data[10][6] = ~sym_data[10][6];
            base = vld_count;
            SCOR = 1'b1;
            tick(2);
            SCOR = 1'b0;
            tick(4);
            for (int i = 0; i < 98; i++) begin
                run_burst(sym_data[i], 1'b0, -1);
                pop();
            end
            tick(3);
            check($sformatf("qcrc%0d_vld_once", pass), 32'(vld_count - base), 32'd1);
            check($sformatf("qcrc%0d_ok", pass), 32'(ok_at_vld), (pass == 0) ? 32'd1 : 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
